// File: rtl/gpio_event_monitor.sv
// gpio_event_monitor: timestamps every change on {gpio,gpio1} into a FIFO and tracks the end-of-test handshake
module gpio_event_monitor #(
  parameter int DEPTH = 16,
  parameter int TS_W = 32,
  parameter logic [31:0] DONE_MAGIC = 32'hCAFE_D00E,
  parameter logic [31:0] PASS_CODE = 32'h0000_0001,
  parameter int DROP_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [31:0] gpio,
  input  logic [31:0] gpio1,
  output logic ev_valid,
  input  logic ev_ready,
  output logic [TS_W-1:0] ev_ts,
  output logic [31:0] ev_gpio,
  output logic [31:0] ev_gpio1,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [DROP_W-1:0] drop_cnt,
  output logic done,
  output logic pass
);
  localparam int AW = $clog2(DEPTH);
  logic [TS_W+63:0] r_mem [DEPTH];
  logic [TS_W-1:0] r_ts;
  logic [63:0] r_prev;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_level;
  logic [DROP_W-1:0] r_drop;
  logic r_done, r_pass;
  logic w_event, w_full, w_pop, w_push, w_drop;
  logic [TS_W+63:0] w_head;
  always_comb begin
    w_event = {gpio, gpio1} != r_prev;
    w_full = r_level == (AW+1)'(DEPTH);
    w_pop = ev_valid && ev_ready;
    // a pop frees the slot in the same cycle, so a full FIFO can still accept
    w_push = w_event && (!w_full || w_pop);
    w_drop = w_event && w_full && !w_pop;
    w_head = r_mem[r_rp];
  end
  assign ev_valid = r_level != '0;
  assign ev_ts = ev_valid ? w_head[TS_W+63:64] : '0;
  assign ev_gpio = ev_valid ? w_head[63:32] : '0;
  assign ev_gpio1 = ev_valid ? w_head[31:0] : '0;
  assign fifo_level = r_level;
  assign drop_cnt = r_drop;
  assign done = r_done;
  assign pass = r_pass;
  always_ff @(posedge clk)
    if (w_push && !rst) r_mem[r_wp] <= {r_ts, gpio, gpio1};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts <= '0;
      r_prev <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_level <= '0;
      r_drop <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      r_prev <= {gpio, gpio1};
      r_wp <= w_push ? r_wp + AW'(1) : r_wp;
      r_rp <= w_pop ? r_rp + AW'(1) : r_rp;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_drop && r_drop != '1) r_drop <= r_drop + DROP_W'(1);
      if (w_event && !r_done && gpio == DONE_MAGIC) begin
        r_done <= 1'b1;
        r_pass <= gpio1 == PASS_CODE;
      end
    end
  end
endmodule

// File: tb/tb_gpio_event_monitor.sv
// tb_gpio_event_monitor: directed and random stimulus checked against a queue-based reference model
module tb_gpio_event_monitor;
  localparam int DEPTH = 16;
  localparam int TS_W = 4;
  localparam logic [31:0] MAGIC = 32'hCAFE_D00E;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] gpio = '0, gpio1 = '0;
  logic ev_ready = 1'b0;
  logic ev_valid, done, pass;
  logic [TS_W-1:0] ev_ts;
  logic [31:0] ev_gpio, ev_gpio1;
  logic [4:0] fifo_level;
  logic [15:0] drop_cnt;
  int n_chk = 0, n_pass = 0;
  logic [TS_W+63:0] q[$];
  int m_ts = 0, m_drop = 0;
  logic [63:0] m_prev = '0;
  bit m_done = 0, m_pass = 0;
  logic [31:0] g, g1;
  gpio_event_monitor #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .gpio(gpio), .gpio1(gpio1), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_ts(ev_ts), .ev_gpio(ev_gpio), .ev_gpio1(ev_gpio1), .fifo_level(fifo_level),
    .drop_cnt(drop_cnt), .done(done), .pass(pass)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask
  task automatic step(input logic [31:0] sg, input logic [31:0] sg1, input logic rdy, input logic r);
    bit v, ev, pop;
    gpio = sg; gpio1 = sg1; ev_ready = rdy; rst = r;
    @(negedge clk);
    v = q.size() != 0;
    check("ev_valid", 64'(ev_valid), 64'(v));
    check("fifo_level", 64'(fifo_level), 64'(q.size()));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("done", 64'(done), 64'(m_done));
    check("pass", 64'(pass), 64'(m_pass));
    check("ev_ts", 64'(ev_ts), v ? 64'(q[0][TS_W+63:64]) : 64'(0));
    check("ev_gpio", 64'(ev_gpio), v ? 64'(q[0][63:32]) : 64'(0));
    check("ev_gpio1", 64'(ev_gpio1), v ? 64'(q[0][31:0]) : 64'(0));
    if (r) begin
      q.delete(); m_ts = 0; m_drop = 0; m_prev = '0; m_done = 0; m_pass = 0;
    end else begin
      ev = {sg, sg1} != m_prev;
      pop = v && rdy;
      if (ev && !pop && q.size() == DEPTH) m_drop = (m_drop == 65535) ? m_drop : m_drop + 1;
      else if (ev) q.push_back({TS_W'(m_ts), sg, sg1});
      if (pop) void'(q.pop_front());
      if (ev && !m_done && sg == MAGIC) begin m_done = 1; m_pass = sg1 == 32'd1; end
      m_prev = {sg, sg1};
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(32'(i + 9), 32'(i), 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(5, 0, 0, 0);
    step(5, 0, 0, 0);
    check("t1_ev_ts", 64'(ev_ts), 64'd4);
    check("t1_ev_gpio", 64'(ev_gpio), 64'd5);
    step(0, 0, 0, 1);
    step(7, 7, 0, 0);
    for (int i = 0; i < 100; i++) step(7, 7, 0, 0);
    check("t2_level", 64'(fifo_level), 64'd1);
    step(7, 7, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(32'(100 + i), 0, 0, 0);
    check("t3_level", 64'(fifo_level), 64'd16);
    check("t3_drop", 64'(drop_cnt), 64'd4);
    check("t3_head", 64'(ev_gpio), 64'd100);
    step(999, 0, 1, 0);
    check("t4_level", 64'(fifo_level), 64'd16);
    check("t4_drop", 64'(drop_cnt), 64'd4);
    for (int i = 0; i < 17; i++) step(999, 0, 1, 0);
    check("t3_drained", 64'(fifo_level), 64'd0);
    step(0, 0, 0, 1);
    step(0, 1, 1, 0);
    step(MAGIC, 1, 1, 0);
    step(1, 1, 1, 0);
    step(2, 3, 1, 0);
    check("t5_done", 64'(done), 64'd1);
    check("t5_pass", 64'(pass), 64'd1);
    step(0, 0, 0, 1);
    step(0, 7, 1, 0);
    step(MAGIC, 7, 1, 0);
    step(3, 1, 1, 0);
    step(MAGIC, 1, 1, 0);
    check("t5_done_fail", 64'(done), 64'd1);
    check("t5_pass_fail", 64'(pass), 64'd0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(32'(i + 1), 1, 0, 0);
    step(MAGIC, 1, 0, 0);
    step(MAGIC, 1, 0, 0);
    check("t5_drop_done", 64'(done), 64'd1);
    check("t5_drop_cnt", 64'(drop_cnt), 64'd1);
    step(0, 0, 0, 1);
    g = 0; g1 = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) g = $urandom;
      if ($urandom_range(0, 3) == 0) g1 = $urandom;
      if (g == MAGIC) g = g ^ 32'd1;
      step(g, g1, 1'($urandom_range(0, 1)), i == 150);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("t6_reset_level", 64'(fifo_level), 64'd0);
    check("t6_reset_done", 64'(done), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
